// File: rtl/shift_pkg.sv
// Shared types and helpers for the shift arbiter controller: op encodings,
// controller FSM states, datapath widths and 64-bit bit reversal.
package shift_pkg;

    localparam int XLEN = 64;
    localparam int SHW  = 6;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        FILL  = 2'b10,
        RESP  = 2'b11
    } state_t;

    function automatic logic [XLEN-1:0] rev64(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = x[XLEN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_sll.sv
// Combinational 64-bit logical left shifter shared by all shift ops.
module shift_sll
    import shift_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [SHW-1:0]  n,
    output logic [XLEN-1:0] result
);

    assign result = a << n;

endmodule

// File: rtl/shift_arbiter_ctrl.sv
// Two-requester arbiter and sequencer around one left shifter; right shifts
// use bit reversal and SRA takes a second pass to build the sign mask.
module shift_arbiter_ctrl #(
    parameter int XLEN  = 64,
    parameter int SHW   = 6,
    parameter bit RR_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*XLEN-1:0]   req_a,
    input  logic [2*SHW-1:0]    req_shamt,
    input  logic [3:0]          req_op,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [XLEN-1:0]     rsp_data
);
    import shift_pkg::*;

    state_t          state;
    logic            rr_ptr;
    logic [XLEN-1:0] a_p0;
    logic [SHW-1:0]  shamt_p0;
    op_t             op_p0;

    logic            grant;
    logic            accept;
    logic [XLEN-1:0] sh_a;
    logic [XLEN-1:0] sh_out;
    logic [XLEN-1:0] sra_mask;
    logic [XLEN-1:0] grant_a;
    logic [SHW-1:0]  grant_shamt;
    logic [1:0]      grant_op;

    // Reserved encoding collapses to SLL at capture so later stages see only three ops.
    function automatic op_t decode_op(input logic [1:0] raw);
        op_t d;
        case (raw)
            2'b01:   d = SH_SRL;
            2'b10:   d = SH_SRA;
            default: d = SH_SLL;
        endcase
        return d;
    endfunction

    always_comb begin
        grant     = rr_ptr;
        req_ready = 2'b00;
        if (!req_valid[rr_ptr]) begin
            grant = ~rr_ptr;
        end
        if (state == IDLE && (|req_valid) && !rst) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign accept      = |(req_valid & req_ready);
    assign grant_a     = grant ? req_a[2*XLEN-1:XLEN] : req_a[XLEN-1:0];
    assign grant_shamt = grant ? req_shamt[2*SHW-1:SHW] : req_shamt[SHW-1:0];
    assign grant_op    = grant ? req_op[3:2] : req_op[1:0];

    // FILL pass shifts all-ones so the reversed complement marks the vacated top bits.
    always_comb begin
        sh_a = (op_p0 == SH_SLL) ? a_p0 : rev64(a_p0);
        if (state == FILL) begin
            sh_a = '1;
        end
    end

    shift_sll u_shift (
        .a      (sh_a),
        .n      (shamt_p0),
        .result (sh_out)
    );

    assign sra_mask = ~rev64(sh_out);

    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            a_p0     <= grant_a;
            shamt_p0 <= grant_shamt;
            op_p0    <= decode_op(grant_op);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= SHIFT;
                        rsp_id <= grant;
                        if (RR_EN) begin
                            rr_ptr <= ~grant;
                        end
                    end
                end
                SHIFT: begin
                    rsp_data  <= (op_p0 == SH_SLL) ? sh_out : rev64(sh_out);
                    state     <= (op_p0 == SH_SRA) ? FILL : RESP;
                    rsp_valid <= (op_p0 != SH_SRA);
                end
                FILL: begin
                    if (a_p0[XLEN-1]) begin
                        rsp_data <= rsp_data | sra_mask;
                    end
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// Directed bench for shift_arbiter_ctrl: ops, edge shift amounts, arbitration
// in both grant modes, response backpressure and reset in the middle of an op.
module tb_shift_arbiter_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [127:0] req_a;
    logic [11:0]  req_shamt;
    logic [3:0]   req_op;
    logic         rsp_ready;

    logic [1:0]   rdy0, rdy1;
    logic         vld0, vld1;
    logic         id0, id1;
    logic [63:0]  data0, data1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    shift_arbiter_ctrl #(.XLEN(64), .SHW(6), .RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0),
        .req_a(req_a), .req_shamt(req_shamt), .req_op(req_op),
        .rsp_valid(vld0), .rsp_ready(rsp_ready), .rsp_id(id0), .rsp_data(data0)
    );

    shift_arbiter_ctrl #(.XLEN(64), .SHW(6), .RR_EN(1'b0)) dut_fixed (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
        .req_a(req_a), .req_shamt(req_shamt), .req_op(req_op),
        .rsp_valid(vld1), .rsp_ready(rsp_ready), .rsp_id(id1), .rsp_data(data1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one request, checks it is granted, and drops valid after the accept edge.
    task automatic issue(input int id, input logic [63:0] a, input logic [5:0] sh,
                         input logic [1:0] op, input string tag);
        @(negedge clk);
        req_a[id*64 +: 64]   = a;
        req_shamt[id*6 +: 6] = sh;
        req_op[id*2 +: 2]    = op;
        req_valid            = 2'b00;
        req_valid[id]        = 1'b1;
        #1;
        chk({tag, ".req_ready"}, 64'(rdy0), (id == 0) ? 64'd1 : 64'd2);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
    endtask

    task automatic expect_rsp(input int lat, input logic [63:0] exp, input logic id,
                              input string tag);
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) begin
                @(negedge clk);
                #1;
            end
            chk($sformatf("%s.rsp_valid_c%0d", tag, k), 64'(vld0), (k == lat) ? 64'd1 : 64'd0);
        end
        chk({tag, ".rsp_data"}, data0, exp);
        chk({tag, ".rsp_id"}, 64'(id0), 64'(id));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_a     = '0;
        req_shamt = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset.rsp_valid", 64'(vld0), 64'd0);
        chk("reset.rsp_data", data0, 64'd0);
        chk("reset.rsp_id", 64'(id0), 64'd0);
        chk("reset.req_ready", 64'(rdy0), 64'd0);
        rst = 1'b0;

        issue(0, 64'h1, 6'd4, 2'b00, "sll");
        expect_rsp(2, 64'h10, 1'b0, "sll");

        issue(1, 64'h8000_0000_0000_0000, 6'd4, 2'b01, "srl");
        expect_rsp(2, 64'h0800_0000_0000_0000, 1'b1, "srl");

        issue(0, 64'h8000_0000_0000_0000, 6'd4, 2'b10, "sra4");
        expect_rsp(3, 64'hF800_0000_0000_0000, 1'b0, "sra4");

        issue(1, 64'h8000_0000_0000_0000, 6'd63, 2'b10, "sra63");
        expect_rsp(3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "sra63");

        issue(0, 64'h8123_4567_89AB_CDEF, 6'd0, 2'b00, "sll0");
        expect_rsp(2, 64'h8123_4567_89AB_CDEF, 1'b0, "sll0");
        issue(0, 64'h8123_4567_89AB_CDEF, 6'd0, 2'b01, "srl0");
        expect_rsp(2, 64'h8123_4567_89AB_CDEF, 1'b0, "srl0");
        issue(0, 64'h8123_4567_89AB_CDEF, 6'd0, 2'b10, "sra0");
        expect_rsp(3, 64'h8123_4567_89AB_CDEF, 1'b0, "sra0");

        issue(1, 64'h1, 6'd1, 2'b11, "rsv");
        expect_rsp(2, 64'h2, 1'b1, "rsv");

        // Arbitration: both requesters valid continuously from reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        req_a     = {64'h1, 64'h1};
        req_shamt = '0;
        req_op    = '0;
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk($sformatf("arb_rr.grant%0d", g), 64'(rdy0), (g % 2 == 0) ? 64'd1 : 64'd2);
            chk($sformatf("arb_fixed.grant%0d", g), 64'(rdy1), 64'd1);
            repeat (3) @(negedge clk);
        end
        req_valid = 2'b00;

        // Backpressure: response held while req0 waits.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        rsp_ready = 1'b0;
        issue(1, 64'hF0, 6'd4, 2'b01, "bp");
        req_a[63:0]    = 64'h5;
        req_shamt[5:0] = 6'd1;
        req_op[1:0]    = 2'b00;
        req_valid      = 2'b01;
        expect_rsp(2, 64'h0F, 1'b1, "bp");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("bp.hold%0d.rsp_valid", c), 64'(vld0), 64'd1);
            chk($sformatf("bp.hold%0d.rsp_data", c), data0, 64'h0F);
            chk($sformatf("bp.hold%0d.rsp_id", c), 64'(id0), 64'd1);
            chk($sformatf("bp.hold%0d.req_ready", c), 64'(rdy0), 64'd0);
        end
        rsp_ready = 1'b1;
        chk("bp.release.req_ready", 64'(rdy0), 64'd0);
        @(negedge clk);
        #1;
        chk("bp.idle.req_ready", 64'(rdy0), 64'd1);
        chk("bp.idle.rsp_valid", 64'(vld0), 64'd0);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        chk("bp.drop.req_ready", 64'(rdy0), 64'd0);
        chk("bp.drop.rsp_valid", 64'(vld0), 64'd0);

        // Reset asserted while an SRA sits in FILL.
        issue(0, 64'h8000_0000_0000_0000, 6'd4, 2'b10, "rstmid");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rstmid.rsp_valid", 64'(vld0), 64'd0);
        chk("rstmid.rsp_data", data0, 64'd0);
        chk("rstmid.rsp_id", 64'(id0), 64'd0);
        chk("rstmid.req_ready", 64'(rdy0), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rstmid.stale1", 64'(vld0), 64'd0);
        @(negedge clk);
        #1;
        chk("rstmid.stale2", 64'(vld0), 64'd0);
        req_valid = 2'b11;
        #1;
        chk("rstmid.rr_ptr", 64'(rdy0), 64'd1);
        req_valid = 2'b00;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
